// File: rtl/calc_seq_undo_if.sv
// Bundle between the calculator sequencer and its surroundings (buttons, switches, ALU, display).
// The slave modport is the sequencer's view; master is the driving environment.
interface calc_seq_undo_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic            i_exec;
  logic            i_undo;
  logic [W-1:0]    i_sw;
  logic [W:0]      i_result;
  logic [W-1:0]    o_op_a;
  logic [W-1:0]    o_op_b;
  logic [1:0]      o_op_sel;
  logic [1:0]      o_state;
  logic [W:0]      o_display;
  logic            o_power_on;
  logic [CntW-1:0] o_hist_cnt;
  logic            o_undo_err;

  modport slave (
    input  i_exec, i_undo, i_sw, i_result,
    output o_op_a, o_op_b, o_op_sel, o_state, o_display, o_power_on, o_hist_cnt, o_undo_err
  );

  modport master (
    output i_exec, i_undo, i_sw, i_result,
    input  o_op_a, o_op_b, o_op_sel, o_state, o_display, o_power_on, o_hist_cnt, o_undo_err
  );
endinterface

// File: rtl/calc_seq_undo.sv
// Calculator entry sequencer (A -> B -> OP -> RESULT, chaining) with a circular
// snapshot history giving DEPTH levels of undo.
module calc_seq_undo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  calc_seq_undo_if.slave  bus
);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned SnapW = 2 + 2 * W + 2;
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  typedef enum logic [1:0] {StA = 2'd0, StB = 2'd1, StOp = 2'd2, StRes = 2'd3} state_e;

  state_e          r_state;
  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic [1:0]      r_op_sel;
  logic [PtrW-1:0] r_ptr;
  logic [CntW-1:0] r_cnt;
  logic            r_undo_err;
  logic [SnapW-1:0] r_hist [DEPTH];

  logic             w_blocked;
  logic             w_push;
  logic             w_undo;
  logic [PtrW-1:0]  w_rd_idx;
  logic [SnapW-1:0] w_snap_wr;
  logic [SnapW-1:0] w_snap_rd;

  // Reserved op code 3 powers the display down and freezes the flow.
  assign w_blocked = (r_state == StOp) && (bus.i_sw[1:0] == 2'b11);
  assign w_push    = bus.i_exec && !w_blocked;
  // exec always takes priority, even when it is itself blocked.
  assign w_undo    = bus.i_undo && !bus.i_exec;
  assign w_rd_idx  = r_ptr - 1'b1;
  assign w_snap_wr = {r_state, r_op_a, r_op_b, r_op_sel};
  assign w_snap_rd = r_hist[w_rd_idx];

  // History storage needs no reset; validity is tracked by r_cnt.
  always_ff @(posedge clk) begin
    if (w_push) r_hist[r_ptr] <= w_snap_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StA;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_sel   <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_undo_err <= 1'b0;
    end else begin
      r_undo_err <= 1'b0;
      if (w_push) begin
        r_ptr <= r_ptr + 1'b1;
        if (r_cnt != CntMax) r_cnt <= r_cnt + 1'b1;
        unique case (r_state)
          StA: begin
            r_op_a  <= bus.i_sw;
            r_state <= StB;
          end
          StB: begin
            r_op_b  <= bus.i_sw;
            r_state <= StOp;
          end
          StOp: begin
            r_op_sel <= bus.i_sw[1:0];
            r_state  <= StRes;
          end
          StRes: begin
            r_op_a  <= bus.i_result[W-1:0];
            r_state <= StB;
          end
          default: r_state <= StA;
        endcase
      end else if (w_undo) begin
        if (r_cnt != '0) begin
          r_ptr    <= w_rd_idx;
          r_cnt    <= r_cnt - 1'b1;
          r_state  <= state_e'(w_snap_rd[SnapW-1 -: 2]);
          r_op_a   <= w_snap_rd[2*W+1 -: W];
          r_op_b   <= w_snap_rd[W+1 -: W];
          r_op_sel <= w_snap_rd[1:0];
        end else begin
          r_undo_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.o_display = {1'b0, bus.i_sw};
    unique case (r_state)
      StA, StB: bus.o_display = {1'b0, bus.i_sw};
      StOp:     bus.o_display = {{(W-1){1'b0}}, bus.i_sw[1:0]};
      StRes:    bus.o_display = bus.i_result;
      default:  bus.o_display = {1'b0, bus.i_sw};
    endcase
  end

  assign bus.o_power_on = !w_blocked;
  assign bus.o_op_a     = r_op_a;
  assign bus.o_op_b     = r_op_b;
  assign bus.o_op_sel   = r_op_sel;
  assign bus.o_state    = r_state;
  assign bus.o_hist_cnt = r_cnt;
  assign bus.o_undo_err = r_undo_err;
endmodule

// File: tb/tb_calc_seq_undo.sv
// Directed-vector bench for calc_seq_undo; the ALU is stubbed as an adder of op_a and op_b.
module tb_calc_seq_undo;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  calc_seq_undo_if #(.W(16), .DEPTH(4)) bus ();

  calc_seq_undo #(.W(16), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.i_result = {1'b0, bus.o_op_a} + {1'b0, bus.o_op_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one cycle of exec/undo with the given switches, return on the next falling edge.
  task automatic step(input logic e, input logic u, input logic [15:0] s);
    @(negedge clk);
    bus.i_exec = e;
    bus.i_undo = u;
    bus.i_sw   = s;
    @(negedge clk);
    bus.i_exec = 1'b0;
    bus.i_undo = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.i_exec = 1'b0;
    bus.i_undo = 1'b0;
    bus.i_sw   = '0;
    rst_n      = 1'b0;
    #12;
    check("rst_state", bus.o_state, 0);
    check("rst_op_a", bus.o_op_a, 0);
    check("rst_op_b", bus.o_op_b, 0);
    check("rst_op_sel", bus.o_op_sel, 0);
    check("rst_hist", bus.o_hist_cnt, 0);
    check("rst_err", bus.o_undo_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Undo with empty history
    step(1'b0, 1'b1, 16'h0000);
    check("empty_undo_err", bus.o_undo_err, 1);
    check("empty_undo_state", bus.o_state, 0);
    check("empty_undo_hist", bus.o_hist_cnt, 0);
    @(negedge clk);
    check("empty_undo_err_1cyc", bus.o_undo_err, 0);

    // Basic entry flow
    step(1'b1, 1'b0, 16'h0012);
    step(1'b1, 1'b0, 16'h0034);
    step(1'b1, 1'b0, 16'h0000);
    check("flow_op_a", bus.o_op_a, 32'h12);
    check("flow_op_b", bus.o_op_b, 32'h34);
    check("flow_op_sel", bus.o_op_sel, 0);
    check("flow_state", bus.o_state, 3);
    check("flow_display", bus.o_display, 32'h46);
    check("flow_hist", bus.o_hist_cnt, 3);
    check("flow_power", bus.o_power_on, 1);

    // Chaining from S_RES
    step(1'b1, 1'b0, 16'h0000);
    check("chain_op_a", bus.o_op_a, 32'h46);
    check("chain_state", bus.o_state, 1);
    check("chain_hist", bus.o_hist_cnt, 4);
    step(1'b0, 1'b1, 16'h0000);
    check("chain_undo_state", bus.o_state, 3);
    check("chain_undo_op_a", bus.o_op_a, 32'h12);
    check("chain_undo_hist", bus.o_hist_cnt, 3);
    check("chain_undo_err", bus.o_undo_err, 0);

    // 6 execs, 5 undos: saturation and LIFO restore
    do_reset();
    step(1'b1, 1'b0, 16'h0001);
    step(1'b1, 1'b0, 16'h0002);
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0005);
    step(1'b1, 1'b0, 16'h0001);
    check("sat_hist", bus.o_hist_cnt, 4);
    check("sat_state", bus.o_state, 3);
    check("sat_op_a", bus.o_op_a, 3);
    check("sat_op_b", bus.o_op_b, 5);
    check("sat_op_sel", bus.o_op_sel, 1);
    step(1'b0, 1'b1, 16'h0000);
    check("u1_state", bus.o_state, 2);
    check("u1_op_b", bus.o_op_b, 5);
    check("u1_op_sel", bus.o_op_sel, 0);
    check("u1_hist", bus.o_hist_cnt, 3);
    step(1'b0, 1'b1, 16'h0000);
    check("u2_state", bus.o_state, 1);
    check("u2_op_a", bus.o_op_a, 3);
    check("u2_op_b", bus.o_op_b, 2);
    check("u2_hist", bus.o_hist_cnt, 2);
    step(1'b0, 1'b1, 16'h0000);
    check("u3_state", bus.o_state, 3);
    check("u3_op_a", bus.o_op_a, 1);
    check("u3_hist", bus.o_hist_cnt, 1);
    step(1'b0, 1'b1, 16'h0000);
    check("u4_state", bus.o_state, 2);
    check("u4_op_a", bus.o_op_a, 1);
    check("u4_op_b", bus.o_op_b, 2);
    check("u4_hist", bus.o_hist_cnt, 0);
    check("u4_err", bus.o_undo_err, 0);
    step(1'b0, 1'b1, 16'h0000);
    check("u5_err", bus.o_undo_err, 1);
    check("u5_state", bus.o_state, 2);
    check("u5_op_a", bus.o_op_a, 1);
    check("u5_op_b", bus.o_op_b, 2);

    // Simultaneous exec and undo in S_B
    do_reset();
    step(1'b1, 1'b0, 16'h0010);
    step(1'b1, 1'b1, 16'h0020);
    check("both_op_b", bus.o_op_b, 32'h20);
    check("both_state", bus.o_state, 2);
    check("both_err", bus.o_undo_err, 0);
    check("both_hist", bus.o_hist_cnt, 2);

    // Reserved op blanks display and blocks exec
    @(negedge clk);
    bus.i_sw = 16'h0003;
    #1;
    check("rsv_power", bus.o_power_on, 0);
    step(1'b1, 1'b0, 16'h0003);
    check("rsv_state", bus.o_state, 2);
    check("rsv_hist", bus.o_hist_cnt, 2);
    bus.i_sw = 16'h0001;
    #1;
    check("op_power", bus.o_power_on, 1);
    check("op_display", bus.o_display, 1);

    // Asynchronous reset mid-S_B
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    check("pre_rst_state", bus.o_state, 1);
    check("pre_rst_hist", bus.o_hist_cnt, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", bus.o_state, 0);
    check("arst_op_a", bus.o_op_a, 0);
    check("arst_op_b", bus.o_op_b, 0);
    check("arst_op_sel", bus.o_op_sel, 0);
    check("arst_hist", bus.o_hist_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 16'h0000);
    check("arst_undo_err", bus.o_undo_err, 1);
    check("arst_undo_state", bus.o_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/calc_seq_undo.md
Name: calc_seq_undo

Overview:
- Sequencing controller for the 17-bit calculator ALU datapath; adds multi-level undo.
- Owns the operand A, operand B and operation registers, and drives the ALU inputs.
- Steps the entry flow A -> B -> OP -> RESULT on debounced exec pulses.
- Keeps a circular snapshot history so that each undo pulse rolls back one exec step.

Parameters:
- DEPTH, 4, number of undo snapshots held (power of two, >=2).
- W, 16, operand width. ALU result width is W+1.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- exec  in  1  one-cycle pulse (debounced BTNC posedge): advance one step
- undo  in  1  one-cycle pulse (debounced posedge): roll back one step
- sw  in  W  switch value to capture
- result  in  W+1  combinational ALU result; bit W is the sign/overflow flag
- op_a  out  W  ALU operand A
- op_b  out  W  ALU operand B
- op_sel  out  2  ALU operation select
- state  out  2  current step: 0=S_A, 1=S_B, 2=S_OP, 3=S_RES
- display  out  W+1  value shown on the seven-segment display
- power_on  out  1  display enable
- hist_cnt  out  clog2(DEPTH+1)  valid snapshots held
- undo_err  out  1  one-cycle pulse when an undo is rejected

Behaviour:
- Reset (asynchronous assert, synchronous release): state=S_A, op_a=0, op_b=0, op_sel=0, hist_cnt=0, undo_err=0, history pointer=0.
- All register updates take effect on the clk edge that samples the pulse; outputs change one cycle after the pulse is seen high.
- Exec transitions (every exec first pushes the snapshot {state,op_a,op_b,op_sel}):
  - S_A: op_a<=sw; go to S_B.
  - S_B: op_b<=sw; go to S_OP.
  - S_OP: op_sel<=sw[1:0]; go to S_RES.
  - S_RES (chaining): op_a<=result[W-1:0], result[W] discarded; go to S_B. op_b and op_sel keep their values.
- History push:
  - Written at the write pointer; pointer increments modulo DEPTH.
  - hist_cnt increments, saturating at DEPTH.
  - When full, a push overwrites the oldest entry; hist_cnt stays at DEPTH.
- Undo with hist_cnt>0:
  - Pointer decrements modulo DEPTH.
  - state, op_a, op_b and op_sel are restored from that entry.
  - hist_cnt decrements.
- Undo with hist_cnt=0: no state change; undo_err=1 for exactly one cycle.
- exec and undo high in the same cycle: exec wins and undo is dropped silently (no undo_err).
- Display and power_on:
  - display = {1'b0,sw} in S_A and S_B.
  - display = {(W-1)'b0,sw[1:0]} in S_OP.
  - display = result in S_RES.
  - power_on=1 in every state except S_OP with sw[1:0]==2'b11 (reserved op). In that case the display blanks and exec is ignored: no push, no state change.
- Reset asserted mid-sequence clears the history immediately; any following undo is rejected.
- No combinational path from exec/undo to the registered outputs. display and power_on are combinational from state, sw and result only.

Test Plan:
- Reset, then exec with sw=0x0012, 0x0034, 0x0000 -> op_a=0x0012, op_b=0x0034, op_sel=0, state=3; with ALU add, display=0x00046.
- From S_RES, exec -> op_a=result[15:0]=0x0046, state=1, hist_cnt=4. Then undo -> state=3, op_a=0x0012, hist_cnt=3.
- Undo right after reset -> undo_err high for exactly 1 cycle; state=0; hist_cnt=0.
- 6 execs then 5 undos with DEPTH=4 -> hist_cnt saturates at 4. Undos 1-4 restore in LIFO order; undo 5 sets undo_err=1 and leaves state equal to the snapshot from after exec 2.
- exec and undo asserted in the same cycle in S_B -> op_b=sw, state=2, undo_err=0, hist_cnt+1.
- In S_OP with sw[1:0]=3: power_on=0, and exec leaves state=2 and hist_cnt unchanged. Reset asserted mid-S_B -> all outputs at reset values in the same cycle (asynchronous).
